// File: rtl/mem_pkg.sv
// Shared types for the memory response port: FSM state encoding and the FIFO entry layout.
package mem_pkg;

   localparam int MEM_ID_W   = 2;
   localparam int MEM_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      SEND  = 3'd2,
      ACK   = 3'd3,
      DRAIN = 3'd4
   } state_t;

   typedef struct packed {
      logic                  last;
      logic [MEM_DATA_W-1:0] data;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/mem_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush.
// Pushes while full and pops while empty are ignored; level counts 0..DEPTH.
module mem_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 9
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      level <= level + LW'(1);
         else if (do_pop && !do_push) level <= level - LW'(1);
      end
   end

   // Storage needs no reset: nothing is read until level says it was written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mem_response_port.sv
// Response stage: buffers flash read bytes, wins the shared data bus, streams the burst and acks
// with the requester id. Define MEM_RESP_TIMEOUT_EN to add the grant-wait timeout and drain path.
//
// state | meaning
// IDLE  | nothing buffered, waiting for a byte
// REQ   | requesting data-bus ownership
// SEND  | bus owned, streaming FIFO head to requester
// ACK   | burst delivered, presenting completion id
// DRAIN | grant timed out, discarding rest of burst
module mem_response_port
   import mem_pkg::*;
#(
   parameter int DEPTH          = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [MEM_DATA_W-1:0]  in_rx_data,
   input  logic                   in_rx_valid,
   input  logic                   in_rx_last,
   input  logic [MEM_ID_W-1:0]    in_dest_id,
   output logic                   out_rx_ready,
   output logic                   out_bus_req,
   input  logic                   in_bus_grant,
   output logic                   out_bus_valid,
   output logic [MEM_DATA_W-1:0]  out_bus_data,
   input  logic                   in_bus_ready,
   output logic                   out_ack_valid,
   output logic [MEM_ID_W-1:0]    out_ack_id,
   input  logic                   in_ack_ready,
   output logic [$clog2(DEPTH):0] out_level,
   output logic                   out_err
);

   state_t              state;
   state_t              state_nx;
   entry_t              fifo_din;
   entry_t              fifo_dout;
   logic                fifo_full;
   logic                fifo_empty;
   logic                push;
   logic                pop;
   logic                flush;
   logic                last_seen;
   logic                ack_done;
   logic [MEM_ID_W-1:0] id_q;

   assign fifo_din = {in_rx_last, in_rx_data};
   assign pop      = (state == SEND) & ~fifo_empty & in_bus_ready;

`ifdef MEM_RESP_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] to_cnt;
   logic          timeout_hit;
   logic          err_q;

   // DRAIN accepts everything so the upstream FSM can finish its burst.
   assign out_rx_ready = (state == DRAIN) | (~fifo_full & ~last_seen);
   assign push         = in_rx_valid & out_rx_ready & (state != DRAIN);
   assign timeout_hit  = (state == REQ) & ~in_bus_grant & (to_cnt == TO_LAST);
   assign flush        = timeout_hit;
   assign out_err      = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= timeout_hit;
         if (state != REQ)          to_cnt <= '0;
         else if (to_cnt != TO_LAST) to_cnt <= to_cnt + TW'(1);
      end
   end
`else
   logic unused_timeout;

   assign out_rx_ready   = ~fifo_full & ~last_seen;
   assign push           = in_rx_valid & out_rx_ready;
   assign flush          = 1'b0;
   assign out_err        = 1'b0;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   mem_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (out_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_seen <= 1'b0;
         id_q      <= '0;
      end else begin
         state <= state_nx;
         if (ack_done || flush)      last_seen <= 1'b0;
         else if (push && in_rx_last) last_seen <= 1'b1;
         if (push && fifo_empty && !last_seen) id_q <= in_dest_id;
      end
   end

   always_comb begin
      state_nx      = state;
      out_bus_req   = 1'b0;
      out_bus_valid = 1'b0;
      out_ack_valid = 1'b0;
      ack_done      = 1'b0;
      case (state)
         IDLE: begin
            // Looking at push as well saves a cycle on the first byte.
            if (!fifo_empty || push) state_nx = REQ;
         end
         REQ: begin
            out_bus_req = 1'b1;
            if (in_bus_grant) state_nx = SEND;
`ifdef MEM_RESP_TIMEOUT_EN
            else if (timeout_hit)
               state_nx = (last_seen || (push && in_rx_last)) ? IDLE : DRAIN;
`endif
         end
         SEND: begin
            out_bus_req   = 1'b1;
            out_bus_valid = ~fifo_empty;
            if (pop && fifo_dout.last) state_nx = ACK;
         end
         ACK: begin
            out_ack_valid = 1'b1;
            if (in_ack_ready) begin
               ack_done = 1'b1;
               state_nx = IDLE;
            end
         end
`ifdef MEM_RESP_TIMEOUT_EN
         DRAIN: begin
            if (in_rx_valid && in_rx_last) state_nx = IDLE;
         end
`endif
         default: state_nx = IDLE;
      endcase
   end

   assign out_bus_data = out_bus_valid ? fifo_dout.data : '0;
   assign out_ack_id   = out_ack_valid ? id_q : '0;

endmodule
